// File: rtl/waterfall_pkg.sv
// Shared constants for the LED waterfall counter and its prescaler.
// Holds the step-mode encodings and the default prescaler divide ratio.
package waterfall_pkg;

    typedef enum logic [1:0] {
        MODE_UP     = 2'b00,
        MODE_DOWN   = 2'b01,
        MODE_BOUNCE = 2'b10,
        MODE_HOLD   = 2'b11
    } mode_t;

    localparam int DEFAULT_TICK_DIV = 100_000_000;

endpackage

// File: rtl/tick_prescaler.sv
// Clock-enable generator: one-cycle tick every TICK_DIV enabled cycles.
// clear restarts the count from zero and drops any pending tick.
module tick_prescaler
    import waterfall_pkg::*;
#(
    parameter int TICK_DIV = DEFAULT_TICK_DIV
) (
    input  logic clk100MHz,
    input  logic reset,
    input  logic en,
    input  logic clear,
    output logic tick
);

    localparam int CNT_W = $clog2(TICK_DIV);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(TICK_DIV - 1);
    localparam logic [CNT_W-1:0] ONE  = CNT_W'(1);

    logic [CNT_W-1:0] div_cnt_reg;
    logic             tick_reg;

    always_ff @(posedge clk100MHz) begin
        if (reset || clear) begin
            div_cnt_reg <= '0;
            tick_reg    <= 1'b0;
        end else if (en) begin
            if (div_cnt_reg == LAST) begin
                div_cnt_reg <= '0;
                tick_reg    <= 1'b1;
            end else begin
                div_cnt_reg <= div_cnt_reg + ONE;
                tick_reg    <= 1'b0;
            end
        end else begin
            tick_reg <= 1'b0;
        end
    end

    assign tick = tick_reg;

endmodule

// File: rtl/waterfall_counter.sv
// Up/down/bounce step counter with programmable bound, load and terminal-count pulse.
// Define WATERFALL_COUNTER_LED_DECODE_EN to add the registered one-hot led output.
module waterfall_counter
    import waterfall_pkg::*;
#(
    parameter int WIDTH    = 4,
    parameter int TICK_DIV = DEFAULT_TICK_DIV,
    parameter int WRAP     = 1
) (
    input  logic             clk100MHz,
    input  logic             reset,
    input  logic             en,
    input  logic [1:0]       mode,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic [WIDTH-1:0] max_val,
    output logic [WIDTH-1:0] Y,
    output logic             dir,
    output logic             tick,
    output logic             tc
`ifdef WATERFALL_COUNTER_LED_DECODE_EN
    ,
    output logic [2**WIDTH-1:0] led
`endif
);

    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

    logic             tick_w;
    logic [WIDTH-1:0] y_reg, y_next;
    logic             dir_reg, dir_next;
    logic             tc_reg, tc_next;

    tick_prescaler #(
        .TICK_DIV (TICK_DIV)
    ) u_prescaler (
        .clk100MHz (clk100MHz),
        .reset     (reset),
        .en        (en),
        .clear     (load),
        .tick      (tick_w)
    );

    // Bounds are tested before any +/-1, so the arithmetic never wraps modulo 2^WIDTH.
    always_comb begin
        y_next   = y_reg;
        dir_next = dir_reg;
        tc_next  = 1'b0;
        if (load) begin
            y_next = (load_val > max_val) ? max_val : load_val;
        end else if (tick_w && en) begin
            case (mode)
                MODE_UP: begin
                    dir_next = 1'b1;
                    if (y_reg > max_val) begin
                        y_next = max_val;
                    end else if (y_reg < max_val) begin
                        y_next = y_reg + ONE;
                    end else begin
                        tc_next = 1'b1;
                        y_next  = (WRAP != 0) ? '0 : y_reg;
                    end
                end
                MODE_DOWN: begin
                    dir_next = 1'b0;
                    if (y_reg > max_val) begin
                        y_next = max_val;
                    end else if (y_reg != '0) begin
                        y_next = y_reg - ONE;
                    end else begin
                        tc_next = 1'b1;
                        y_next  = (WRAP != 0) ? max_val : y_reg;
                    end
                end
                MODE_BOUNCE: begin
                    if (y_reg > max_val) begin
                        y_next = max_val;
                    end else if (max_val == '0) begin
                        dir_next = ~dir_reg;
                        tc_next  = 1'b1;
                    end else if (dir_reg) begin
                        if (y_reg < max_val) begin
                            y_next = y_reg + ONE;
                        end else begin
                            dir_next = 1'b0;
                            y_next   = max_val - ONE;
                            tc_next  = 1'b1;
                        end
                    end else begin
                        if (y_reg != '0) begin
                            y_next = y_reg - ONE;
                        end else begin
                            dir_next = 1'b1;
                            y_next   = ONE;
                            tc_next  = 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk100MHz) begin
        if (reset) begin
            y_reg   <= '0;
            dir_reg <= 1'b1;
            tc_reg  <= 1'b0;
        end else begin
            y_reg   <= y_next;
            dir_reg <= dir_next;
            tc_reg  <= tc_next;
        end
    end

    assign Y    = y_reg;
    assign dir  = dir_reg;
    assign tick = tick_w;
    assign tc   = tc_reg;

`ifdef WATERFALL_COUNTER_LED_DECODE_EN
    localparam logic [2**WIDTH-1:0] LED_ONE = (2**WIDTH)'(1);

    logic [2**WIDTH-1:0] led_reg;

    generate
        if (WIDTH > 6) begin : g_width_check
            $error("waterfall_counter: led decode supports WIDTH <= 6");
        end
    endgenerate

    // Decoded from y_next so led moves on the same edge as Y.
    always_ff @(posedge clk100MHz) begin
        if (reset) begin
            led_reg <= LED_ONE;
        end else begin
            led_reg <= LED_ONE << y_next;
        end
    end

    assign led = led_reg;
`endif

endmodule

// File: tb/tb_waterfall_counter.sv
// Bench for waterfall_counter: a wrapping and a saturating instance driven in parallel
// and compared every cycle against an integer reference model of the step rules.
module tb_waterfall_counter;
    localparam int W  = 4;
    localparam int TD = 4;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         en = 1'b0;
    logic [1:0]   mode = 2'b00;
    logic         load = 1'b0;
    logic [W-1:0] load_val = '0;
    logic [W-1:0] max_val = 4'd15;

    logic [W-1:0] y_w, y_s;
    logic         dir_w, dir_s, tick_w, tick_s, tc_w, tc_s;
`ifdef WATERFALL_COUNTER_LED_DECODE_EN
    logic [2**W-1:0] led_w, led_s;
`endif

    int checks = 0;
    int passes = 0;

    int m_y[2];
    bit m_dir[2];
    bit m_tc[2];
    bit m_tick;
    int m_div;

    always #5 clk = ~clk;

    waterfall_counter #(.WIDTH(W), .TICK_DIV(TD), .WRAP(1)) dut_wrap (
        .clk100MHz(clk), .reset(reset), .en(en), .mode(mode), .load(load),
        .load_val(load_val), .max_val(max_val), .Y(y_w), .dir(dir_w),
        .tick(tick_w), .tc(tc_w)
`ifdef WATERFALL_COUNTER_LED_DECODE_EN
        , .led(led_w)
`endif
    );

    waterfall_counter #(.WIDTH(W), .TICK_DIV(TD), .WRAP(0)) dut_sat (
        .clk100MHz(clk), .reset(reset), .en(en), .mode(mode), .load(load),
        .load_val(load_val), .max_val(max_val), .Y(y_s), .dir(dir_s),
        .tick(tick_s), .tc(tc_s)
`ifdef WATERFALL_COUNTER_LED_DECODE_EN
        , .led(led_s)
`endif
    );

    // One step of the counter rules applied to model instance i.
    task automatic model_step(input int i);
        int mx;
        bit wrap;
        mx = int'(max_val);
        wrap = (i == 0);
        if (mode == 2'b11) return;
        if (mode == 2'b00) m_dir[i] = 1'b1;
        if (mode == 2'b01) m_dir[i] = 1'b0;
        if (m_y[i] > mx) begin
            m_y[i] = mx;
        end else if (mode == 2'b00) begin
            if (m_y[i] < mx) m_y[i] = m_y[i] + 1;
            else begin m_tc[i] = 1'b1; if (wrap) m_y[i] = 0; end
        end else if (mode == 2'b01) begin
            if (m_y[i] > 0) m_y[i] = m_y[i] - 1;
            else begin m_tc[i] = 1'b1; if (wrap) m_y[i] = mx; end
        end else if (mx == 0) begin
            m_dir[i] = !m_dir[i];
            m_tc[i] = 1'b1;
        end else if (m_dir[i]) begin
            if (m_y[i] < mx) m_y[i] = m_y[i] + 1;
            else begin m_dir[i] = 1'b0; m_y[i] = mx - 1; m_tc[i] = 1'b1; end
        end else begin
            if (m_y[i] > 0) m_y[i] = m_y[i] - 1;
            else begin m_dir[i] = 1'b1; m_y[i] = 1; m_tc[i] = 1'b1; end
        end
    endtask

    task automatic model_edge();
        bit fire;
        if (reset) begin
            for (int i = 0; i < 2; i++) begin m_y[i] = 0; m_dir[i] = 1'b1; m_tc[i] = 1'b0; end
            m_tick = 1'b0;
            m_div = 0;
        end else if (load) begin
            for (int i = 0; i < 2; i++) begin
                m_y[i] = (load_val > max_val) ? int'(max_val) : int'(load_val);
                m_tc[i] = 1'b0;
            end
            m_tick = 1'b0;
            m_div = 0;
        end else begin
            fire = m_tick && en;
            if (en) begin
                if (m_div == TD - 1) begin m_div = 0; m_tick = 1'b1; end
                else begin m_div = m_div + 1; m_tick = 1'b0; end
            end else begin
                m_tick = 1'b0;
            end
            for (int i = 0; i < 2; i++) begin
                m_tc[i] = 1'b0;
                if (fire) model_step(i);
            end
        end
    endtask

    task automatic step_clk();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    function automatic logic [W+2:0] exp_vec(input int i);
        return {W'(m_y[i]), m_dir[i], m_tick, m_tc[i]};
    endfunction

    task automatic test_reset();
        reset = 1'b1;
        for (int c = 0; c < 3; c++) begin
            step_clk();
            checks++;
            if ({y_w, tick_w, tc_w, dir_w} !== {4'd0, 1'b0, 1'b0, 1'b1})
                $display("FAIL reset_state got Y=%0d tick=%0b tc=%0b dir=%0b want Y=0 tick=0 tc=0 dir=1",
                         y_w, tick_w, tc_w, dir_w);
            else passes++;
`ifdef WATERFALL_COUNTER_LED_DECODE_EN
            checks++;
            if (led_w !== 16'h0001) $display("FAIL reset_led got %h want 0001", led_w);
            else passes++;
`endif
        end
        $display("reset: Y=%0d dir=%0b tick=%0b tc=%0b", y_w, dir_w, tick_w, tc_w);
        reset = 1'b0;
        en = 1'b1;
        mode = 2'b00;
        max_val = 4'd15;
    endtask

    task automatic test_up_wrap();
        int ticks = 0;
        for (int c = 0; c < 17 * TD + 2; c++) begin
            step_clk();
            ticks += tick_w;
            checks++;
            if ({y_w, dir_w, tick_w, tc_w} !== exp_vec(0))
                $display("FAIL up_wrap t=%0t got %b want %b", $time, {y_w, dir_w, tick_w, tc_w}, exp_vec(0));
            else passes++;
        end
        checks++;
        if (ticks !== 17) $display("FAIL up_tick_count got %0d want 17", ticks);
        else passes++;
        $display("up_wrap: %0d ticks, final Y=%0d", ticks, y_w);
    endtask

    task automatic test_down();
        load = 1'b1; load_val = 4'd0; max_val = 4'd9; mode = 2'b01;
        step_clk();
        load = 1'b0;
        for (int c = 0; c < 12 * TD; c++) begin
            step_clk();
            checks += 2;
            if ({y_w, dir_w, tick_w, tc_w} !== exp_vec(0))
                $display("FAIL down_wrap t=%0t got %b want %b", $time, {y_w, dir_w, tick_w, tc_w}, exp_vec(0));
            else passes++;
            if ({y_s, dir_s, tick_s, tc_s} !== exp_vec(1))
                $display("FAIL down_sat t=%0t got %b want %b", $time, {y_s, dir_s, tick_s, tc_s}, exp_vec(1));
            else passes++;
        end
        $display("down: wrap Y=%0d sat Y=%0d", y_w, y_s);
    endtask

    task automatic test_bounce(input logic [W-1:0] mx, input int steps);
        load = 1'b1; load_val = 4'd0; max_val = mx; mode = 2'b10;
        step_clk();
        load = 1'b0;
        for (int c = 0; c < steps * TD; c++) begin
            step_clk();
            checks += 2;
            if ({y_w, dir_w, tick_w, tc_w} !== exp_vec(0))
                $display("FAIL bounce_w max=%0d t=%0t got %b want %b", mx, $time, {y_w, dir_w, tick_w, tc_w}, exp_vec(0));
            else passes++;
            if ({y_s, dir_s, tick_s, tc_s} !== exp_vec(1))
                $display("FAIL bounce_s max=%0d t=%0t got %b want %b", mx, $time, {y_s, dir_s, tick_s, tc_s}, exp_vec(1));
            else passes++;
        end
        $display("bounce max=%0d: Y=%0d dir=%0b", mx, y_w, dir_w);
    endtask

    task automatic test_load_on_tick();
        int guard = 0;
        mode = 2'b00; max_val = 4'd15;
        while (!tick_w && guard < 2 * TD) begin step_clk(); guard++; end
        checks++;
        if (tick_w !== 1'b1) $display("FAIL load_tick_wait got tick=%0b want 1", tick_w);
        else passes++;
        load = 1'b1; load_val = 4'd12; max_val = 4'd7;
        step_clk();
        load = 1'b0;
        checks++;
        if ({y_w, tick_w, tc_w} !== {4'd7, 1'b0, 1'b0})
            $display("FAIL load_clamp got Y=%0d tick=%0b tc=%0b want Y=7 tick=0 tc=0", y_w, tick_w, tc_w);
        else passes++;
        for (int c = 1; c <= TD + 2; c++) begin
            step_clk();
            checks++;
            if ({y_w, dir_w, tick_w, tc_w} !== exp_vec(0))
                $display("FAIL load_after cyc=%0d got %b want %b", c, {y_w, dir_w, tick_w, tc_w}, exp_vec(0));
            else passes++;
        end
        $display("load_on_tick: Y=%0d", y_w);
    endtask

    task automatic test_range_guard();
        load = 1'b1; load_val = 4'd10; max_val = 4'd15; mode = 2'b00;
        step_clk();
        load = 1'b0; max_val = 4'd5;
        for (int c = 0; c < TD + 1; c++) step_clk();
        checks++;
        if ({y_w, tc_w} !== {4'd5, 1'b0}) $display("FAIL range_guard got Y=%0d tc=%0b want Y=5 tc=0", y_w, tc_w);
        else passes++;
        $display("range_guard: Y=%0d tc=%0b", y_w, tc_w);
    endtask

    task automatic test_enable_freeze();
        logic [W-1:0] y_hold;
        max_val = 4'd15; mode = 2'b00;
        step_clk(); step_clk();
        en = 1'b0;
        step_clk();
        y_hold = y_w;
        for (int c = 0; c < 10; c++) begin
            step_clk();
            checks++;
            if ({y_w, tick_w, tc_w} !== {y_hold, 1'b0, 1'b0})
                $display("FAIL freeze got Y=%0d tick=%0b want Y=%0d tick=0", y_w, tick_w, y_hold);
            else passes++;
        end
        en = 1'b1;
        for (int c = 0; c < 2 * TD; c++) begin
            step_clk();
            checks++;
            if ({y_w, dir_w, tick_w, tc_w} !== exp_vec(0))
                $display("FAIL resume t=%0t got %b want %b", $time, {y_w, dir_w, tick_w, tc_w}, exp_vec(0));
            else passes++;
        end
        $display("enable_freeze: held Y=%0d, resumed Y=%0d", y_hold, y_w);
    endtask

    task automatic test_random();
        for (int c = 0; c < 1500; c++) begin
            en = ($urandom_range(0, 9) != 0);
            if ($urandom_range(0, 15) == 0) mode = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 40) == 0) max_val = W'($urandom_range(0, 15));
            load = ($urandom_range(0, 30) == 0);
            load_val = W'($urandom_range(0, 15));
            reset = ($urandom_range(0, 250) == 0);
            step_clk();
            checks += 2;
            if ({y_w, dir_w, tick_w, tc_w} !== exp_vec(0))
                $display("FAIL random_w t=%0t got %b want %b", $time, {y_w, dir_w, tick_w, tc_w}, exp_vec(0));
            else passes++;
            if ({y_s, dir_s, tick_s, tc_s} !== exp_vec(1))
                $display("FAIL random_s t=%0t got %b want %b", $time, {y_s, dir_s, tick_s, tc_s}, exp_vec(1));
            else passes++;
`ifdef WATERFALL_COUNTER_LED_DECODE_EN
            checks++;
            if (led_w !== (16'h0001 << m_y[0])) $display("FAIL led got %h want Y=%0d one-hot", led_w, m_y[0]);
            else passes++;
`endif
        end
        reset = 1'b0; load = 1'b0;
        $display("random: 1500 cycles, final Y=%0d/%0d", y_w, y_s);
    endtask

    initial begin
        test_reset();
        test_up_wrap();
        test_down();
        test_bounce(4'd3, 8);
        test_bounce(4'd0, 5);
        test_load_on_tick();
        test_range_guard();
        test_enable_freeze();
        test_random();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/waterfall_counter.md
Name: waterfall_counter

Overview:
- Parametrised up/down/bounce step counter for the LED waterfall path; successor to the fixed 4-bit, 1 Hz up/down counter.
- Uses a single clock domain with an internal prescaler that produces a one-cycle clock-enable tick. No divided clock is generated.
- Adds programmable upper bound, synchronous load, bounce (ping-pong) mode, wrap/saturate policy and a terminal-count pulse.
- Drives LED/7-seg decode logic downstream.

Parameters:
- WIDTH, 4, counter width in bits (1..16).
- TICK_DIV, 100_000_000, clk100MHz cycles per count step (>=2); default gives 1 step/s.
- WRAP, 1, 1 = wrap at bounds in up/down modes; 0 = saturate.

Ports:
- clk100MHz  input  1  system clock, 100 MHz.
- reset  input  1  synchronous, active-high reset.
- en  input  1  1 = prescaler runs; 0 = prescaler and count frozen.
- mode  input  2  00 up, 01 down, 10 bounce, 11 hold.
- load  input  1  synchronous load strobe.
- load_val  input  WIDTH  value to load.
- max_val  input  WIDTH  upper bound; count range is 0..max_val.
- Y  output  WIDTH  current count (registered).
- dir  output  1  current direction, 1 = up (registered).
- tick  output  1  one-cycle prescaler pulse (registered).
- tc  output  1  one-cycle terminal-count pulse, aligned with Y update.

Behaviour:
- Reset (sampled on clk100MHz edge while reset=1) overrides everything:
  - Y=0, dir=1, tick=0, tc=0, prescaler div_cnt=0.
  - Reset mid-step discards any pending tick.
- Prescaler:
  - div_cnt counts 0..TICK_DIV-1 while en=1, width $clog2(TICK_DIV).
  - tick is registered high for exactly one cycle on the edge where div_cnt wraps TICK_DIV-1 -> 0.
  - en=0: div_cnt holds and tick is 0 next cycle.
- Step timing: Y, dir and tc update on the edge where tick=1 and en=1. Y therefore changes one cycle after tick rises. tc is 0 on all other cycles.
- Priority per edge: reset > load > step.
- Load:
  - Y <= min(load_val, max_val), div_cnt <= 0, tick <= 0, tc <= 0; dir unchanged.
  - A step coinciding with load is dropped.
- Out-of-range guard: if Y > max_val at a step (max_val lowered at runtime), Y <= max_val and tc=0, in any mode except hold.
- Up mode, dir <= 1:
  - Y<max_val: Y+1.
  - Y==max_val: WRAP ? 0 : hold; tc=1 either way.
- Down mode, dir <= 0:
  - Y>0: Y-1.
  - Y==0: WRAP ? max_val : hold; tc=1.
- Bounce mode (WRAP ignored), dir kept from previous mode:
  - dir=1 and Y<max_val: Y+1.
  - dir=1 and Y==max_val: dir<=0, Y<=max_val-1, tc=1.
  - dir=0 and Y>0: Y-1.
  - dir=0 and Y==0: dir<=1, Y<=1, tc=1.
  - max_val==0: Y stays 0, dir toggles, tc=1 every step.
- Hold mode: Y and dir unchanged, tc=0; tick still generated.
- All arithmetic is modulo-2^WIDTH free, because the bounds checks precede the +/-1.
- Mode changes take effect on the next step only.

Optional Feature:
- Macro WATERFALL_COUNTER_LED_DECODE_EN.
- Defined:
  - Adds output led[2**WIDTH-1:0], registered one-hot of Y (led[Y]=1), updated the same edge as Y.
  - Reset value 1 (led[0]=1).
  - Compile-time error if WIDTH>6.
- Undefined: port absent, no decode logic, all other behaviour identical.

Decomposition:
- Shared package waterfall_pkg holds:
  - mode encodings MODE_UP=2'b00, MODE_DOWN=2'b01, MODE_BOUNCE=2'b10, MODE_HOLD=2'b11;
  - default TICK_DIV constant 100_000_000.
- One natural sub-module: tick_prescaler (params TICK_DIV; ports clk100MHz, reset, en, clear, tick). It is reusable by the 7-seg scan logic.

Test Plan (TICK_DIV=4, WIDTH=4, WRAP=1 unless stated):
- Reset then en=1, mode=up, max_val=15 -> tick every 4 cycles; Y steps 0,1,...,15,0; tc=1 only on 15->0; Y and tick low during reset.
- Mode=down from Y=0, max_val=9 -> Y goes 9,8,...,0,9; tc on 0->9. Repeat with WRAP=0 -> Y sticks at 0, tc pulses each step.
- Mode=bounce, max_val=3, from Y=0 -> Y sequence 1,2,3,2,1,0,1; dir flips at 3 and 0 with tc=1. With max_val=0 -> Y=0, dir toggles each step.
- load=1, load_val=12, max_val=7, asserted on the same edge as tick -> Y=7, no step, next tick 4 cycles later.
- Y=10 and max_val lowered to 5 in up mode -> next step gives Y=5, tc=0. en=0 for 10 cycles -> no tick, Y frozen, div_cnt resumes from held value.
- With WATERFALL_COUNTER_LED_DECODE_EN defined -> led==1<<Y every cycle; led=16'h0001 after reset.
